accumulator_ctrl: RTL and testbench

- Sequencing controller for the shift-accumulator array.
- Accepts one output tile job: K partial-sum passes of SIZE rows each. It gates rows from the upstream source into the array and marks the first pass as init data.
- Waits for each pass to drain through the accumulator chain, then issues the SIZE-cycle calc_done read-out burst and reports tile completion.
- Includes a watchdog that flags a hung array.

---
 rtl/accumulator_ctrl.sv | 167 ++++++++++++++++
 tb/tb_accumulator_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_ctrl
// Brief    : Sequencing controller for the shift-accumulator array. Runs one
//            tile job of K partial-sum passes (SIZE rows each). It marks the
//            first pass as init data, waits for each pass to drain, issues the
//            SIZE-cycle calc_done read-out burst and reports completion. A
//            watchdog flags an array that never answers.
// Revision : 1.0 - initial release
// ============================================================================
module accumulator_ctrl #(
    parameter int SIZE       = 16,
    parameter int PASS_WIDTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [PASS_WIDTH-1:0] k_passes_i,
    input  logic                  row_valid_i,
    output logic                  row_ready_o,
    output logic                  acc_valid_o,
    output logic                  acc_init_o,
    output logic                  acc_done_o,
    input  logic                  partial_sum_calc_over_i,
    input  logic                  tile_calc_over_i,
    output logic                  busy_o,
    output logic [PASS_WIDTH-1:0] pass_cnt_o,
    output logic                  tile_done_o,
    output logic                  error_o
);

    // Counter widths sized so the terminal values SIZE-1 and TIMEOUT-1 fit.
    localparam int C_ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int C_WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [C_ROW_W-1:0]    C_ROW_LAST = C_ROW_W'(SIZE - 1);
    localparam logic [C_WD_W-1:0]     C_WD_LAST  = C_WD_W'(TIMEOUT - 1);
    localparam logic [PASS_WIDTH-1:0] C_ONE      = PASS_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FEED      = 3'd1,
        S_WAIT_PSUM = 3'd2,
        S_DRAIN     = 3'd3,
        S_WAIT_OVER = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                r_state;
    logic [PASS_WIDTH-1:0] r_k;
    logic [PASS_WIDTH-1:0] r_pass_cnt;
    logic [C_ROW_W-1:0]    r_row_cnt;
    logic [C_ROW_W-1:0]    r_drain_cnt;
    logic [C_WD_W-1:0]     r_wd_cnt;
    logic                  r_acc_done;
    logic                  r_tile_done;
    logic                  r_error;

    logic                  w_row_ready;
    logic                  w_xfer;
    logic                  w_last_pass;
    logic                  w_wd_expired;

    // Row handshake is combinational so a row transfers in the cycle it is offered.
    always_comb begin
        w_row_ready  = (r_state == S_FEED);
        w_xfer       = row_valid_i & w_row_ready;
        w_last_pass  = (r_pass_cnt == (r_k - C_ONE));
        w_wd_expired = (r_wd_cnt == C_WD_LAST);
    end

    // Job sequencer: pass/row/drain counting, watchdog and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_pass_cnt  <= '0;
            r_row_cnt   <= '0;
            r_drain_cnt <= '0;
            r_wd_cnt    <= '0;
            r_acc_done  <= 1'b0;
            r_tile_done <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_tile_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        // A zero pass count is treated as a single pass.
                        r_k        <= (k_passes_i == '0) ? C_ONE : k_passes_i;
                        r_pass_cnt <= '0;
                        r_row_cnt  <= '0;
                        r_error    <= 1'b0;
                        r_state    <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (w_xfer) begin
                        if (r_row_cnt == C_ROW_LAST) begin
                            r_row_cnt <= '0;
                            r_wd_cnt  <= '0;
                            r_state   <= S_WAIT_PSUM;
                        end else begin
                            r_row_cnt <= r_row_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT_PSUM: begin
                    // The awaited pulse takes priority over watchdog expiry.
                    if (partial_sum_calc_over_i) begin
                        if (w_last_pass) begin
                            r_drain_cnt <= '0;
                            r_acc_done  <= 1'b1;
                            r_state     <= S_DRAIN;
                        end else begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                            r_state    <= S_FEED;
                        end
                    end else if (w_wd_expired) begin
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == C_ROW_LAST) begin
                        r_acc_done <= 1'b0;
                        r_wd_cnt   <= '0;
                        r_state    <= S_WAIT_OVER;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_WAIT_OVER: begin
                    if (tile_calc_over_i) begin
                        r_tile_done <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_wd_expired) begin
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign row_ready_o = w_row_ready;
    assign acc_valid_o = w_xfer;
    assign acc_init_o  = w_xfer & (r_pass_cnt == '0);
    assign acc_done_o  = r_acc_done;
    assign busy_o      = (r_state != S_IDLE);
    assign pass_cnt_o  = r_pass_cnt;
    assign tile_done_o = r_tile_done;
    assign error_o     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulator_ctrl
// Brief    : Self-checking bench for accumulator_ctrl (SIZE=4, TIMEOUT=16).
//            Expected per-row init/pass values are queued as rows are driven
//            and popped whenever the DUT reports a transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulator_ctrl;

    localparam int C_SIZE    = 4;
    localparam int C_PW      = 16;
    localparam int C_TIMEOUT = 16;

    logic            clk;
    logic            rst_n;
    logic            start_i;
    logic [C_PW-1:0] k_passes_i;
    logic            row_valid_i;
    logic            row_ready_o;
    logic            acc_valid_o;
    logic            acc_init_o;
    logic            acc_done_o;
    logic            partial_sum_calc_over_i;
    logic            tile_calc_over_i;
    logic            busy_o;
    logic [C_PW-1:0] pass_cnt_o;
    logic            tile_done_o;
    logic            error_o;

    accumulator_ctrl #(
        .SIZE       (C_SIZE),
        .PASS_WIDTH (C_PW),
        .TIMEOUT    (C_TIMEOUT)
    ) u_dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start_i                 (start_i),
        .k_passes_i              (k_passes_i),
        .row_valid_i             (row_valid_i),
        .row_ready_o             (row_ready_o),
        .acc_valid_o             (acc_valid_o),
        .acc_init_o              (acc_init_o),
        .acc_done_o              (acc_done_o),
        .partial_sum_calc_over_i (partial_sum_calc_over_i),
        .tile_calc_over_i        (tile_calc_over_i),
        .busy_o                  (busy_o),
        .pass_cnt_o              (pass_cnt_o),
        .tile_done_o             (tile_done_o),
        .error_o                 (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            init;
        logic [C_PW-1:0] pass;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_xfer   = 0;
    int   n_done   = 0;
    int   n_tile   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Negedge sampling: pops scoreboard entries on transfers, counts strobes.
    task automatic sample();
        exp_t e;
        if (acc_valid_o) begin
            n_xfer++;
            if (sb.size() == 0) begin
                chk("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("acc_init", 32'(acc_init_o), 32'(e.init));
                chk("xfer_pass_cnt", 32'(pass_cnt_o), 32'(e.pass));
            end
        end
        if (acc_done_o)  n_done++;
        if (tile_done_o) n_tile++;
    endtask

    // One clock: sample at negedge, then land #1 after the next posedge.
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [C_PW-1:0] k);
        start_i    = 1'b1;
        k_passes_i = k;
        step();
        start_i    = 1'b0;
        chk("start_row_ready", 32'(row_ready_o), 32'd1);
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_pass_cnt", 32'(pass_cnt_o), 32'd0);
    endtask

    task automatic feed_pass(input int pass_idx, input bit gaps);
        int rows  = 0;
        int guard = 0;
        logic v;
        exp_t e;
        while (rows < C_SIZE && guard < 64) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            row_valid_i = v;
            if (v) begin
                e.init = (pass_idx == 0);
                e.pass = C_PW'(pass_idx);
                sb.push_back(e);
            end
            step();
            if (v) rows++;
            guard++;
        end
        row_valid_i = 1'b0;
        if (guard >= 64) chk("feed_timeout", 32'd1, 32'd0);
        chk("wait_psum_ready", 32'(row_ready_o), 32'd0);
        chk("wait_psum_pass", 32'(pass_cnt_o), 32'(pass_idx));
    endtask

    task automatic psum_pulse(input int dly);
        repeat (dly) step();
        partial_sum_calc_over_i = 1'b1;
        step();
        partial_sum_calc_over_i = 1'b0;
    endtask

    task automatic tail(input int over_dly);
        repeat (C_SIZE) step();
        chk("wait_over_done", 32'(acc_done_o), 32'd0);
        chk("wait_over_busy", 32'(busy_o), 32'd1);
        repeat (over_dly) step();
        tile_calc_over_i = 1'b1;
        step();
        tile_calc_over_i = 1'b0;
        chk("tile_done_pulse", 32'(tile_done_o), 32'd1);
        step();
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_tile_done", 32'(tile_done_o), 32'd0);
    endtask

    task automatic run_job(input logic [C_PW-1:0] k, input bit gaps, input int npass);
        int x0 = n_xfer;
        int d0 = n_done;
        int t0 = n_tile;
        start_job(k);
        for (int p = 0; p < npass; p++) begin
            feed_pass(p, gaps);
            psum_pulse(3);
        end
        tail(5);
        chk("job_xfers", 32'(n_xfer - x0), 32'(npass * C_SIZE));
        chk("job_drain_cycles", 32'(n_done - d0), 32'(C_SIZE));
        chk("job_tile_pulses", 32'(n_tile - t0), 32'd1);
        chk("job_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"},
            32'({row_ready_o, acc_valid_o, acc_init_o, acc_done_o, busy_o, tile_done_o, error_o}),
            32'd0);
        chk({tag, "_pass"}, 32'(pass_cnt_o), 32'd0);
    endtask

    initial begin
        int d0;
        int t0;
        rst_n                   = 1'b0;
        start_i                 = 1'b0;
        k_passes_i              = '0;
        row_valid_i             = 1'b0;
        partial_sum_calc_over_i = 1'b0;
        tile_calc_over_i        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Stray pulses in IDLE are ignored.
        partial_sum_calc_over_i = 1'b1;
        tile_calc_over_i        = 1'b1;
        step();
        partial_sum_calc_over_i = 1'b0;
        tile_calc_over_i        = 1'b0;
        chk_all_zero("stray_idle");

        // Single pass, continuous rows.
        run_job(16'd1, 1'b0, 1);
        // Three passes with random row gaps.
        run_job(16'd3, 1'b1, 3);
        // Zero passes behaves as one.
        run_job(16'd0, 1'b0, 1);

        // start_i while busy is ignored: k=2 job survives a k=7 start.
        d0 = n_done;
        t0 = n_tile;
        start_job(16'd2);
        start_i    = 1'b1;
        k_passes_i = 16'd7;
        step();
        start_i    = 1'b0;
        chk("restart_busy", 32'(busy_o), 32'd1);
        chk("restart_pass", 32'(pass_cnt_o), 32'd0);
        feed_pass(0, 1'b0);
        psum_pulse(2);
        feed_pass(1, 1'b0);
        psum_pulse(1);
        chk("restart_drain", 32'(acc_done_o), 32'd1);
        tail(2);
        chk("restart_drain_cycles", 32'(n_done - d0), 32'(C_SIZE));
        chk("restart_tile", 32'(n_tile - t0), 32'd1);

        // Watchdog: no partial-sum pulse ever arrives.
        t0 = n_tile;
        start_job(16'd1);
        feed_pass(0, 1'b0);
        repeat (C_TIMEOUT - 1) step();
        chk("wd_pre_error", 32'(error_o), 32'd0);
        chk("wd_pre_busy", 32'(busy_o), 32'd1);
        step();
        chk("wd_error", 32'(error_o), 32'd1);
        chk("wd_idle", 32'(busy_o), 32'd0);
        repeat (3) step();
        chk("wd_error_hold", 32'(error_o), 32'd1);
        chk("wd_no_tile", 32'(n_tile - t0), 32'd0);
        start_job(16'd1);
        chk("wd_error_clear", 32'(error_o), 32'd0);
        feed_pass(0, 1'b0);
        psum_pulse(0);
        tail(0);

        // Asynchronous reset in the middle of the drain burst.
        t0 = n_tile;
        start_job(16'd1);
        feed_pass(0, 1'b0);
        psum_pulse(1);
        step();
        chk("mid_drain_done", 32'(acc_done_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        step();
        rst_n = 1'b1;
        chk("reset_no_tile", 32'(n_tile - t0), 32'd0);
        step();
        run_job(16'd2, 1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard bound on total simulation time.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
